serial_add4: RTL and testbench

- Bit-serial ripple adder; the addition-direction counterpart to the team's 4-bit borrow-chain subtractor.
- Computes s = a + b + ci over WIDTH clock cycles, using one full-adder cell plus a carry flip-flop.
- Uses a start/busy/done handshake, so a controller or datapath sequencer can issue operations and collect results.
- Used where a single reused adder cell is preferred over a parallel carry chain.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/full_add1.sv | 17 +
 rtl/serial_add4.sv | 113 +++++++++++
 tb/tb_serial_add4.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: default operand width and
// the controller state encoding.
package serial_add_pkg;

  // Operand width used when the parent does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Controller state encoding, kept as plain 2-bit constants so older
  // sequencers that decode the state bits directly still match.
  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/full_add1.sv
// One-bit full adder cell. Same truth table as the subtractor cell, with
// the borrow chain replaced by a carry chain.
module full_add1 (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum is the parity of the three inputs; carry is the majority.
  always_comb begin
    sum  = x ^ y ^ cin;
    cout = (x & y) | (cin & (x ^ y));
  end

endmodule

// File: rtl/serial_add4.sv
// Bit-serial ripple adder. One full adder cell and a carry flip-flop
// process the operands LSB first over WIDTH cycles, with a start/busy/done
// handshake so a sequencer can issue back-to-back operations.
module serial_add4
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 sum bits already produced; the final bit comes
  // straight from the adder cell when the result is published.
  logic [WIDTH-2:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    count;

  logic             accept;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_cat;

  // The single reused adder cell works on the current LSBs and the carry.
  full_add1 u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Decode the handshake: a request is taken only when not mid-operation,
  // and the last bit is the one processed with count at WIDTH-1.
  always_comb begin
    accept   = start && ((state == IDLE) || (state == DONE));
    last_bit = (state == SHIFT) && (count == LAST_BIT);
    sum_cat  = {fa_sum, sum_sr};
  end

  // Next-state logic; DONE lasts one cycle and may chain straight into SHIFT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: capture operands on accept, shift one bit per SHIFT cycle,
  // and publish {co,s} only when the final bit has been produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      s      <= '0;
      co     <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= ci;
      count <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_cout;
      sum_sr <= sum_cat[WIDTH-1:1];
      count  <= count + CW'(1);
      if (last_bit) begin
        s  <= sum_cat;
        co <= fa_cout;
      end
    end
  end

  // Status outputs decode directly from the registered state, so busy and
  // done can never be high together.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_add4.sv
// Directed bench for serial_add4 with hand-computed results, a
// back-to-back run, an asynchronous reset mid-operation and a full sweep.
module tb_serial_add4;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  int               check_count;
  int               pass_count;
  logic [WIDTH-1:0] held_s;
  logic             held_co;

  serial_add4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  // Free-running clock, rising edge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one operation with a single-cycle start pulse, follow it to its
  // done pulse and check handshake timing, output stability and the result.
  task automatic applyStimulus(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                               input logic op_ci, input logic [WIDTH:0] expected_sum);
    int   waited;
    int   busy_cycles;
    logic stable;
    logic overlap;
    logic got_done;
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    ci    = op_ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~op_a;
    b     = ~op_b;
    ci    = ~op_ci;
    waited      = 0;
    busy_cycles = 0;
    stable      = 1'b1;
    overlap     = 1'b0;
    got_done    = 1'b0;
    while (!got_done && waited < 20) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        if (s !== held_s || co !== held_co) stable = 1'b0;
        waited++;
        @(negedge clk);
      end
    end
    checkOutput("done_seen", {31'd0, got_done}, 32'd1);
    checkOutput("latency", waited, WIDTH);
    checkOutput("busy_cycles", busy_cycles, WIDTH);
    checkOutput("held_stable", {31'd0, stable}, 32'd1);
    checkOutput("busy_done_overlap", {31'd0, overlap}, 32'd0);
    checkOutput("result", {27'd0, co, s}, {27'd0, expected_sum});
    held_s  = expected_sum[WIDTH-1:0];
    held_co = expected_sum[WIDTH];
    @(negedge clk);
    checkOutput("done_one_cycle", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int   bad;
    logic done_seen;
    check_count = 0;
    pass_count  = 0;
    held_s      = '0;
    held_co     = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;

    // Reset state
    #12;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_s", {28'd0, s}, 32'd0);
    checkOutput("reset_co", {31'd0, co}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single operations
    $display("[TB] directed operations");
    applyStimulus(4'h5, 4'h3, 1'b0, 5'h08);
    applyStimulus(4'hF, 4'h1, 1'b0, 5'h10);
    applyStimulus(4'hF, 4'hF, 1'b1, 5'h1F);
    applyStimulus(4'h0, 4'h0, 1'b1, 5'h01);
    applyStimulus(4'hA, 4'h5, 1'b0, 5'h0F);

    // Back-to-back with start held high; operands changed during SHIFT are ignored
    $display("[TB] back-to-back");
    @(negedge clk);
    a = 4'h2; b = 4'h2; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'hF; b = 4'hF; ci = 1'b1;
    bad = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || s !== held_s || co !== held_co) bad++;
      @(negedge clk);
    end
    checkOutput("b2b_first_shift", bad, 0);
    checkOutput("b2b_first_done", {31'd0, done}, 32'd1);
    checkOutput("b2b_first_result", {27'd0, co, s}, 32'h04);
    a = 4'h7; b = 4'h9; ci = 1'b0;
    @(negedge clk);
    a = 4'h1; b = 4'h1; ci = 1'b1;
    checkOutput("b2b_no_idle_gap", {30'd0, busy, done}, 32'd2);
    bad = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || s !== 4'h4 || co !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput("b2b_second_shift", bad, 0);
    checkOutput("b2b_second_done", {31'd0, done}, 32'd1);
    checkOutput("b2b_second_result", {27'd0, co, s}, 32'h10);
    start = 1'b0;
    held_s  = 4'h0;
    held_co = 1'b1;
    @(negedge clk);
    checkOutput("b2b_back_to_idle", {30'd0, busy, done}, 32'd0);

    // Asynchronous reset two cycles into SHIFT
    $display("[TB] reset mid-operation");
    @(negedge clk);
    a = 4'h5; b = 4'h3; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {26'd0, busy, done, co, s}, 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    checkOutput("no_done_after_reset", {31'd0, done_seen}, 32'd0);
    checkOutput("s_cleared_by_reset", {27'd0, co, s}, 32'd0);
    held_s  = '0;
    held_co = 1'b0;
    applyStimulus(4'h5, 4'h3, 1'b0, 5'h08);

    // Exhaustive sweep against the arithmetic reference a+b+ci
    $display("[TB] exhaustive sweep");
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          applyStimulus(WIDTH'(ia), WIDTH'(ib), 1'(ic), (WIDTH+1)'(ia + ib + ic));
        end
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
